decode_stage: RTL and testbench
===============================

# decode_stage

Parametrised, handshaked instruction decode stage for the ARM-style CPU datapath. It sits between the fetch stage and the register-file/execute stage. It registers one decoded instruction per accepted fetch word, expands immediates to XLEN bits (rotated, offset and branch forms) and carries the fetch PC alongside. Unlike a free-running decoder, it supports backpressure, flush, compare/store semantics, link branches and illegal-opcode detection.

## Interface
- XLEN, 32, width of PC and expanded immediate (must be >= 26)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- flush  in  1  synchronous; discards all held and incoming instructions
- in_valid  in  1  fetch word valid
- in_ready  out  1  stage can accept a word this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  PC of in_instr
- out_valid  out  1  decoded instruction valid
- out_ready  in  1  downstream accepts this cycle
- out_pc  out  XLEN  PC of the decoded instruction
- out_cond  out  4  instr[31:28]
- out_cmd  out  4  ALU command
- out_rd, out_rn, out_rm  out  4 each  register indices
- out_imm  out  XLEN  expanded immediate
- out_imm_sel  out  1  ALU operand B is out_imm rather than rm
- out_set_flags, out_mem, out_mem_wr, out_reg_wr, out_branch, out_link, out_illegal  out  1 each  control

## Operation
- Transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready; order strictly FIFO.
- op=instr[27:26]:
  - 00 data-proc: cmd=[24:21], rn=[19:16], rd=[15:12], set_flags=[20]; reg_wr=1 except cmd 1000–1011 (TST/TEQ/CMP/CMN) -> 0. [25]=1: imm=ror(zext([7:0]),2*[11:8]), imm_sel=1, rm=0; else rm=[3:0], imm=0, imm_sel=0.
  - 01 memory: mem=1, rn=[19:16], rd=[15:12]; [20]=1 load -> reg_wr=1, mem_wr=0; [20]=0 store -> reg_wr=0, mem_wr=1. cmd=0100 if U=[23]=1 else 0010. [25]=0: imm=zext([11:0]), imm_sel=1, rm=0; else rm=[3:0], imm_sel=0, imm=0.
  - 10 branch: branch=1, link=[24], imm=sext([23:0])<<2, imm_sel=1; link -> reg_wr=1, rd=14; else reg_wr=0, rd=0. rn=rm=cmd=0.
  - 11: illegal=1, every other control bit and field 0 except out_cond, out_pc.
- Fields not listed for an opcode are 0.
- flush: all held entries invalidated at the edge; a simultaneous input transfer is dropped; in_ready unaffected.

## Timing
- Latency 1 cycle: word accepted at edge N is on out_* after edge N, out_valid=1.
- out_* stable while out_valid&&!out_ready.
- Reset (async, rst=0): out_valid=0, all out_* fields 0, entries empty; in_ready=1 once rst=1. Reset mid-transfer loses held instructions, no partial state.
- Simultaneous accept and drain on a full-1 stage: allowed, throughput 1/cycle.
- out_* are 0 whenever out_valid=0.

## Configuration
- DECODE_SKID_EN defined: 2-entry skid buffer; in_ready is a flop (=entries<2, computed from next state), no combinational out_ready->in_ready path; up to 2 instructions held under backpressure.
- Undefined: single output register; in_ready = !out_valid || out_ready (combinational); at most 1 held.

## Test plan
- 0xE2810005 (ADD R0,R1,#5), out_ready=1 -> next cycle out_valid=1, cmd=0100, rn=1, rd=0, imm=5, imm_sel=1, reg_wr=1, out_pc = in_pc.
- 0xE3A004FF -> cmd=1101, imm=0xFF000000; 0xE1510002 (CMP R1,R2) -> rm=2, reg_wr=0, set_flags=1, imm_sel=0.
- 0xE5932008 (LDR R2,[R3,#8]) -> mem=1, reg_wr=1, mem_wr=0, cmd=0100, rn=3, rd=2, imm=8; 0xE5032004 (STR) -> mem_wr=1, reg_wr=0, cmd=0010, imm=4.
- 0xEBFFFFFE (BL -8) -> branch=1, link=1, reg_wr=1, rd=14, imm=0xFFFFFFF8; 0xEC000000 -> illegal=1, all other controls 0.
- out_ready=0, 3 words offered back-to-back -> with DECODE_SKID_EN 2 accepted then in_ready=0; without, 1 accepted; release out_ready -> all words emerge in order, none lost or duplicated.
- flush with 2 held plus in_valid=1 -> next cycle out_valid=0, nothing of those emerges; rst=0 mid-stream -> out_valid=0 and all outputs 0 immediately (asynchronous).

Source files
------------

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake plus the decoded-instruction bus of decode_stage.
// master = fetch/execute environment side, slave = decode_stage itself.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [3:0]      out_cond;
    logic [3:0]      out_cmd;
    logic [3:0]      out_rd;
    logic [3:0]      out_rn;
    logic [3:0]      out_rm;
    logic [XLEN-1:0] out_imm;
    logic            out_imm_sel;
    logic            out_set_flags;
    logic            out_mem;
    logic            out_mem_wr;
    logic            out_reg_wr;
    logic            out_branch;
    logic            out_link;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_cond, out_cmd, out_rd, out_rn, out_rm,
               out_imm, out_imm_sel, out_set_flags, out_mem, out_mem_wr, out_reg_wr,
               out_branch, out_link, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_cond, out_cmd, out_rd, out_rn, out_rm,
               out_imm, out_imm_sel, out_set_flags, out_mem, out_mem_wr, out_reg_wr,
               out_branch, out_link, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// Handshaked ARM-style decode stage: one registered decoded instruction per fetch word.
// DECODE_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave dec_io
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [3:0]      cond;
        logic [3:0]      cmd;
        logic [3:0]      rd;
        logic [3:0]      rn;
        logic [3:0]      rm;
        logic [XLEN-1:0] imm;
        logic            imm_sel;
        logic            set_flags;
        logic            mem;
        logic            mem_wr;
        logic            reg_wr;
        logic            branch;
        logic            link;
        logic            illegal;
    } dec_t;

    // Rotation happens across the full XLEN word after zero extension.
    function automatic logic [XLEN-1:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [XLEN-1:0] z;
        int              amt;
        z   = XLEN'(imm8);
        amt = 2 * int'(rot);
        return (z >> amt) | (z << ((XLEN - amt) % XLEN));
    endfunction

    function automatic logic [XLEN-1:0] branch_imm(input logic [23:0] off);
        logic signed [23:0]   s;
        logic signed [XLEN-1:0] ext;
        s   = off;
        ext = {{(XLEN-24){s[23]}}, s};
        return ext <<< 2;
    endfunction

    function automatic dec_t decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        dec_t d;
        d      = '0;
        d.pc   = pc;
        d.cond = ins[31:28];
        case (ins[27:26])
            2'b00: begin
                d.cmd       = ins[24:21];
                d.rn        = ins[19:16];
                d.rd        = ins[15:12];
                d.set_flags = ins[20];
                d.reg_wr    = (ins[24:23] != 2'b10);
                if (ins[25]) begin
                    d.imm     = rot_imm(ins[7:0], ins[11:8]);
                    d.imm_sel = 1'b1;
                end else begin
                    d.rm = ins[3:0];
                end
            end
            2'b01: begin
                d.mem    = 1'b1;
                d.rn     = ins[19:16];
                d.rd     = ins[15:12];
                d.reg_wr = ins[20];
                d.mem_wr = !ins[20];
                d.cmd    = ins[23] ? 4'b0100 : 4'b0010;
                if (!ins[25]) begin
                    d.imm     = XLEN'(ins[11:0]);
                    d.imm_sel = 1'b1;
                end else begin
                    d.rm = ins[3:0];
                end
            end
            2'b10: begin
                d.branch  = 1'b1;
                d.link    = ins[24];
                d.imm     = branch_imm(ins[23:0]);
                d.imm_sel = 1'b1;
                if (ins[24]) begin
                    d.reg_wr = 1'b1;
                    d.rd     = 4'd14;
                end
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    dec_t head;
    logic head_vld;

`ifdef DECODE_SKID_EN
    dec_t       ent0_q, ent0_d, ent1_q, ent1_d;
    logic [1:0] vld_q, vld_d;
    logic       rdy_q, rdy_d;
    logic       push, pop;

    // Entries stay compacted toward ent0, so "two held" is exactly vld[1].
    always_comb begin
        pop    = vld_q[0] && dec_io.out_ready;
        push   = dec_io.in_valid && rdy_q && !dec_io.flush;
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        vld_d  = vld_q;
        if (pop) begin
            ent0_d   = ent1_q;
            vld_d[0] = vld_q[1];
            ent1_d   = '0;
            vld_d[1] = 1'b0;
        end
        if (push) begin
            if (!vld_d[0]) begin
                ent0_d   = decode(dec_io.in_instr, dec_io.in_pc);
                vld_d[0] = 1'b1;
            end else begin
                ent1_d   = decode(dec_io.in_instr, dec_io.in_pc);
                vld_d[1] = 1'b1;
            end
        end
        if (dec_io.flush) begin
            ent0_d = '0;
            ent1_d = '0;
            vld_d  = '0;
        end
        rdy_d = !vld_d[1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_q <= '0;
            ent1_q <= '0;
            vld_q  <= '0;
            rdy_q  <= 1'b1;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            vld_q  <= vld_d;
            rdy_q  <= rdy_d;
        end
    end

    assign dec_io.in_ready = rdy_q;
    assign head            = ent0_q;
    assign head_vld        = vld_q[0];
`else
    dec_t out_q, out_d;
    logic vld_q, vld_d;
    logic rdy;

    assign rdy = !vld_q || dec_io.out_ready;

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (vld_q && dec_io.out_ready) begin
            out_d = '0;
            vld_d = 1'b0;
        end
        if (dec_io.in_valid && rdy) begin
            out_d = decode(dec_io.in_instr, dec_io.in_pc);
            vld_d = 1'b1;
        end
        if (dec_io.flush) begin
            out_d = '0;
            vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q <= '0;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign dec_io.in_ready = rdy;
    assign head            = out_q;
    assign head_vld        = vld_q;
`endif

    // Held entries are cleared when they leave, so the bus reads 0 while idle.
    assign dec_io.out_valid     = head_vld;
    assign dec_io.out_pc        = head.pc;
    assign dec_io.out_cond      = head.cond;
    assign dec_io.out_cmd       = head.cmd;
    assign dec_io.out_rd        = head.rd;
    assign dec_io.out_rn        = head.rn;
    assign dec_io.out_rm        = head.rm;
    assign dec_io.out_imm       = head.imm;
    assign dec_io.out_imm_sel   = head.imm_sel;
    assign dec_io.out_set_flags = head.set_flags;
    assign dec_io.out_mem       = head.mem;
    assign dec_io.out_mem_wr    = head.mem_wr;
    assign dec_io.out_reg_wr    = head.reg_wr;
    assign dec_io.out_branch    = head.branch;
    assign dec_io.out_link      = head.link;
    assign dec_io.out_illegal   = head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (default or DECODE_SKID_EN build).
module tb_decode_stage;
    localparam int XLEN = 32;
    localparam int VW   = 1 + 4 * 5 + XLEN + 8 + XLEN;
`ifdef DECODE_SKID_EN
    localparam int HOLD = 2;
`else
    localparam int HOLD = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    decode_stage_if #(.XLEN(XLEN)) dif ();
    decode_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .dec_io(dif));

    always #5 clk = ~clk;

    // valid, cond, cmd, rd, rn, rm, imm, {imm_sel,set_flags,mem,mem_wr,reg_wr,branch,link,illegal}, pc
    logic [VW-1:0] act;
    assign act = {dif.out_valid, dif.out_cond, dif.out_cmd, dif.out_rd, dif.out_rn, dif.out_rm,
                  dif.out_imm, dif.out_imm_sel, dif.out_set_flags, dif.out_mem, dif.out_mem_wr,
                  dif.out_reg_wr, dif.out_branch, dif.out_link, dif.out_illegal, dif.out_pc};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [31:0] instr, input logic [XLEN-1:0] pc);
        dif.in_valid = 1'b1;
        dif.in_instr = instr;
        dif.in_pc    = pc;
        tick();
        dif.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick();
        tick();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", act);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", dif.in_ready);
        end
    endtask

    task automatic test_dataproc();
        logic [31:0]   ins [3];
        logic [VW-1:0] exp [3];
        ins[0] = 32'hE2810005;
        exp[0] = {1'b1, 4'hE, 4'h4, 4'h0, 4'h1, 4'h0, 32'h00000005, 8'b1000_1000, 32'h100};
        ins[1] = 32'hE3A004FF;
        exp[1] = {1'b1, 4'hE, 4'hD, 4'h0, 4'h0, 4'h0, 32'hFF000000, 8'b1000_1000, 32'h104};
        ins[2] = 32'hE1510002;
        exp[2] = {1'b1, 4'hE, 4'hA, 4'h0, 4'h1, 4'h2, 32'h00000000, 8'b0100_0000, 32'h108};
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_one(ins[i], 32'h100 + 32'(4 * i));
            checks++;
            if (act !== exp[i]) begin
                errors++;
                $display("FAIL dataproc[%0d] got %h want %h", i, act, exp[i]);
            end
        end
    endtask

    task automatic test_memory();
        logic [31:0]   ins [3];
        logic [VW-1:0] exp [3];
        ins[0] = 32'hE5932008;
        exp[0] = {1'b1, 4'hE, 4'h4, 4'h2, 4'h3, 4'h0, 32'h00000008, 8'b1010_1000, 32'h10C};
        ins[1] = 32'hE5032004;
        exp[1] = {1'b1, 4'hE, 4'h2, 4'h2, 4'h3, 4'h0, 32'h00000004, 8'b1011_0000, 32'h110};
        ins[2] = 32'h07912003;
        exp[2] = {1'b1, 4'h0, 4'h4, 4'h2, 4'h1, 4'h3, 32'h00000000, 8'b0010_1000, 32'h114};
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_one(ins[i], 32'h10C + 32'(4 * i));
            checks++;
            if (act !== exp[i]) begin
                errors++;
                $display("FAIL memory[%0d] got %h want %h", i, act, exp[i]);
            end
        end
    endtask

    task automatic test_branch_illegal();
        logic [31:0]   ins [3];
        logic [VW-1:0] exp [3];
        ins[0] = 32'hEBFFFFFE;
        exp[0] = {1'b1, 4'hE, 4'h0, 4'hE, 4'h0, 4'h0, 32'hFFFFFFF8, 8'b1000_1110, 32'h118};
        ins[1] = 32'h1A000010;
        exp[1] = {1'b1, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000040, 8'b1000_0100, 32'h11C};
        ins[2] = 32'hEC000000;
        exp[2] = {1'b1, 4'hE, 4'h0, 4'h0, 4'h0, 4'h0, 32'h00000000, 8'b0000_0001, 32'h120};
        dif.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send_one(ins[i], 32'h118 + 32'(4 * i));
            checks++;
            if (act !== exp[i]) begin
                errors++;
                $display("FAIL branch[%0d] got %h want %h", i, act, exp[i]);
            end
        end
        tick();
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL idle_zero got %h want 0", act);
        end
    endtask

    task automatic test_back_to_back();
        dif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            dif.in_valid = 1'b1;
            dif.in_instr = 32'hE2810000 | 32'(i);
            dif.in_pc    = 32'h200 + 32'(4 * i);
            #1;
            checks++;
            if (dif.in_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready[%0d] got %b want 1", i, dif.in_ready);
            end
            tick();
            checks++;
            if (dif.out_valid !== 1'b1 || dif.out_pc !== 32'h200 + 32'(4 * i)) begin
                errors++;
                $display("FAIL b2b_out[%0d] got v=%b pc=%h want v=1 pc=%h", i,
                         dif.out_valid, dif.out_pc, 32'h200 + 32'(4 * i));
            end
        end
        dif.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [XLEN-1:0] pcs [3];
        logic [XLEN-1:0] got [$];
        int              acc;
        logic            rdy, offered;
        pcs[0] = 32'h300;
        pcs[1] = 32'h304;
        pcs[2] = 32'h308;
        acc = 0;
        dif.out_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            offered      = (acc < 3);
            dif.in_valid = offered;
            dif.in_instr = 32'hE2810000 | 32'(acc);
            dif.in_pc    = pcs[(acc < 3) ? acc : 2];
            #1;
            rdy = dif.in_ready;
            tick();
            if (offered && rdy) acc++;
        end
        checks++;
        if (acc !== HOLD) begin
            errors++;
            $display("FAIL bp_accepted got %0d want %0d", acc, HOLD);
        end
        checks++;
        if (dif.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_in_ready got %b want 0", dif.in_ready);
        end
        dif.out_ready = 1'b1;
        for (int c = 0; c < 20 && got.size() < 3; c++) begin
            offered      = (acc < 3);
            dif.in_valid = offered;
            dif.in_instr = 32'hE2810000 | 32'(acc);
            dif.in_pc    = pcs[(acc < 3) ? acc : 2];
            #1;
            rdy = dif.in_ready;
            if (dif.out_valid) got.push_back(dif.out_pc);
            tick();
            if (offered && rdy) acc++;
        end
        dif.in_valid = 1'b0;
        checks++;
        if (got.size() != 3) begin
            errors++;
            $display("FAIL bp_drained got %0d want 3", got.size());
        end
        for (int i = 0; i < got.size() && i < 3; i++) begin
            checks++;
            if (got[i] !== pcs[i]) begin
                errors++;
                $display("FAIL bp_order[%0d] got %h want %h", i, got[i], pcs[i]);
            end
        end
        tick();
        tick();
        checks++;
        if (dif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup got %b want 0", dif.out_valid);
        end
    endtask

    task automatic test_flush();
        logic seen;
        dif.out_ready = 1'b0;
        dif.in_instr  = 32'hE2810005;
        dif.in_valid  = 1'b1;
        dif.in_pc     = 32'h400;
        tick();
        dif.in_pc = 32'h404;
        tick();
        checks++;
        if (dif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_held got %b want 1", dif.out_valid);
        end
        dif.in_pc = 32'h408;
        dif.flush = 1'b1;
        tick();
        dif.flush    = 1'b0;
        dif.in_valid = 1'b0;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL flush_outputs got %h want 0", act);
        end
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_in_ready got %b want 1", dif.in_ready);
        end
        dif.out_ready = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (dif.out_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_nothing_emerges got %b want 0", seen);
        end
    endtask

    task automatic test_async_reset();
        dif.out_ready = 1'b0;
        send_one(32'hE3A004FF, 32'h500);
        checks++;
        if (dif.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre_held got %b want 1", dif.out_valid);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (act !== '0) begin
            errors++;
            $display("FAIL areset_immediate got %h want 0", act);
        end
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (act !== '0 || dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL areset_after got %h rdy=%b want 0 rdy=1", act, dif.in_ready);
        end
        dif.out_ready = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        dif.flush     = 1'b0;
        dif.in_valid  = 1'b0;
        dif.in_instr  = '0;
        dif.in_pc     = '0;
        dif.out_ready = 1'b0;
        #2;
        test_reset();
        test_dataproc();
        test_memory();
        test_branch_illegal();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
